// File: rtl/chg_list_fetch.sv
// -----------------------------------------------------------------------------
// chg_list_fetch
//
// Upstream sequencer for the Y-matrix update datapath. Walks the change list
// held in a synchronous (1-cycle latency) change memory one entry at a time,
// presents each entry to the Y-update stage and waits for its done pulse
// before fetching the next. Emits a single list_done pulse at list end.
//
// Optional feature macro: CHG_SKIP_ZERO_EN
//   defined   : entries with real==0 and img==0 are not issued; they are
//               counted in skip_cnt instead.
//   undefined : every entry is issued, skip_cnt stays 0.
//
// Ports
//   clock        in   single clock, rising edge
//   reset        in   asynchronous, active-low
//   start        in   list request, sampled only in IDLE
//   chg_count    in   number of entries (ADDR_W+1 bits), latched on start
//   chg_rd_en    out  change-memory read strobe
//   chg_addr     out  change-memory read address
//   chg_rdata    in   read data {row[79:64], col[63:48], real[47:24], img[23:0]}
//   upd_done     in   done pulse from the update stage (used in WAIT_DONE only)
//   chgTxt_*     out  current entry fields
//   entry_valid  out  one-cycle pulse, chgTxt_* hold a new entry
//   entry_idx    out  index of the current entry
//   busy         out  high in every state except IDLE
//   list_done    out  one-cycle pulse at list completion
//   skip_cnt     out  number of skipped entries
// -----------------------------------------------------------------------------
module chg_list_fetch #(
    parameter int ADDR_W = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   chg_count,
    output logic              chg_rd_en,
    output logic [ADDR_W-1:0] chg_addr,
    input  logic [79:0]       chg_rdata,
    input  logic              upd_done,
    output logic [15:0]       chgTxt_row,
    output logic [15:0]       chgTxt_col,
    output logic [23:0]       chgTxt_real,
    output logic [23:0]       chgTxt_img,
    output logic              entry_valid,
    output logic [ADDR_W:0]   entry_idx,
    output logic              busy,
    output logic              list_done,
    output logic [ADDR_W:0]   skip_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_RD,
        S_ISSUE,
        S_WAIT_DONE,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [ADDR_W:0]   skip_q, skip_d;
    logic [ADDR_W:0]   eidx_q, eidx_d;
    logic [15:0]       row_q, row_d;
    logic [15:0]       col_q, col_d;
    logic [23:0]       re_q, re_d;
    logic [23:0]       im_q, im_d;

    // Output registers, loaded from the next state so each output is a
    // plain flop with no input-to-output combinational path.
    logic              rd_en_q;
    logic [ADDR_W-1:0] addr_q;
    logic              ev_q;
    logic              done_q;
    logic              busy_q;

    logic [ADDR_W:0]   idx_inc;
    logic              last_entry;
    logic              skip_entry;

    // Full-width compare so a count of 2^ADDR_W terminates without wrapping.
    assign idx_inc    = idx_q + ONE;
    assign last_entry = (idx_inc == cnt_q);

`ifdef CHG_SKIP_ZERO_EN
    assign skip_entry = (chg_rdata[47:24] == 24'd0) && (chg_rdata[23:0] == 24'd0);
`else
    assign skip_entry = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        skip_d  = skip_q;
        eidx_d  = eidx_q;
        row_d   = row_q;
        col_d   = col_q;
        re_d    = re_q;
        im_d    = im_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d   = chg_count;
                    idx_d   = '0;
                    skip_d  = '0;
                    state_d = (chg_count == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_WAIT_RD;
            end
            S_WAIT_RD: begin
                if (skip_entry) begin
                    idx_d   = idx_inc;
                    skip_d  = skip_q + ONE;
                    state_d = last_entry ? S_DONE : S_FETCH;
                end else begin
                    row_d   = chg_rdata[79:64];
                    col_d   = chg_rdata[63:48];
                    re_d    = chg_rdata[47:24];
                    im_d    = chg_rdata[23:0];
                    eidx_d  = idx_q;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // A done pulse here belongs to no issued entry; ignore it.
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (upd_done) begin
                    idx_d   = idx_inc;
                    state_d = last_entry ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            skip_q  <= '0;
            eidx_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            re_q    <= '0;
            im_q    <= '0;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            ev_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            skip_q  <= skip_d;
            eidx_q  <= eidx_d;
            row_q   <= row_d;
            col_q   <= col_d;
            re_q    <= re_d;
            im_q    <= im_d;
            rd_en_q <= (state_d == S_FETCH);
            if (state_d == S_FETCH) begin
                addr_q <= idx_d[ADDR_W-1:0];
            end
            ev_q    <= (state_d == S_ISSUE);
            done_q  <= (state_d == S_DONE);
            busy_q  <= (state_d != S_IDLE);
        end
    end

    assign chg_rd_en   = rd_en_q;
    assign chg_addr    = addr_q;
    assign chgTxt_row  = row_q;
    assign chgTxt_col  = col_q;
    assign chgTxt_real = re_q;
    assign chgTxt_img  = im_q;
    assign entry_valid = ev_q;
    assign entry_idx   = eidx_q;
    assign busy        = busy_q;
    assign list_done   = done_q;
    assign skip_cnt    = skip_q;

endmodule

// File: tb/tb_chg_list_fetch.sv
// -----------------------------------------------------------------------------
// tb_chg_list_fetch
//
// Scoreboarded bench for chg_list_fetch (ADDR_W=2, so a full list is 4).
// The stimulus side computes, from the list contents, which addresses must be
// read, which entries must be issued and how many are skipped, and pushes
// those into queues. A separate monitor pops and compares whenever the DUT
// strobes chg_rd_en, entry_valid or list_done.
// -----------------------------------------------------------------------------
module tb_chg_list_fetch;

    localparam int AW    = 2;
    localparam int CW    = AW + 1;
    localparam int DEPTH = 1 << AW;

`ifdef CHG_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic          clock    = 1'b0;
    logic          reset    = 1'b0;
    logic          start    = 1'b0;
    logic          upd_done = 1'b0;
    logic [AW:0]   chg_count = '0;
    logic [79:0]   chg_rdata = '0;
    logic          chg_rd_en;
    logic [AW-1:0] chg_addr;
    logic [15:0]   chgTxt_row, chgTxt_col;
    logic [23:0]   chgTxt_real, chgTxt_img;
    logic          entry_valid;
    logic [AW:0]   entry_idx;
    logic          busy;
    logic          list_done;
    logic [AW:0]   skip_cnt;

    chg_list_fetch #(.ADDR_W(AW)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .chg_count   (chg_count),
        .chg_rd_en   (chg_rd_en),
        .chg_addr    (chg_addr),
        .chg_rdata   (chg_rdata),
        .upd_done    (upd_done),
        .chgTxt_row  (chgTxt_row),
        .chgTxt_col  (chgTxt_col),
        .chgTxt_real (chgTxt_real),
        .chgTxt_img  (chgTxt_img),
        .entry_valid (entry_valid),
        .entry_idx   (entry_idx),
        .busy        (busy),
        .list_done   (list_done),
        .skip_cnt    (skip_cnt)
    );

    always #5 clock = ~clock;

    // Change memory: synchronous read, one cycle latency.
    logic [79:0] mem [DEPTH];
    always @(posedge clock) begin
        if (chg_rd_en) chg_rdata <= mem[chg_addr];
    end

    typedef struct {
        logic [15:0] row;
        logic [15:0] col;
        logic [23:0] re;
        logic [23:0] im;
        int          idx;
    } exp_t;

    exp_t exp_q[$];
    int   addr_q[$];
    int   done_q[$];
    int   gap_q[$];
    int   trail;
    exp_t last_exp;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input string what);
        n_vec++;
        n_err++;
        $display("FAIL %s: %s", name, what);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        exp_t e;
        int   a;
        int   s;
        if (chg_rd_en) begin
            if (addr_q.size() == 0) flag("chg_rd_en", $sformatf("unexpected read of addr %0d, none required", chg_addr));
            else begin
                a = addr_q.pop_front();
                chk("chg_addr", 32'(chg_addr), 32'(a));
            end
        end
        if (entry_valid) begin
            if (exp_q.size() == 0) flag("entry_valid", $sformatf("unexpected pulse idx %0d, none required", entry_idx));
            else begin
                e = exp_q.pop_front();
                chk("entry_idx", 32'(entry_idx), 32'(e.idx));
                chk("chgTxt_row", 32'(chgTxt_row), 32'(e.row));
                chk("chgTxt_col", 32'(chgTxt_col), 32'(e.col));
                chk("chgTxt_real", 32'(chgTxt_real), 32'(e.re));
                chk("chgTxt_img", 32'(chgTxt_img), 32'(e.im));
                $display("entry idx=%0d row=%0h col=%0h re=%0h im=%0h", entry_idx, chgTxt_row, chgTxt_col, chgTxt_real, chgTxt_img);
            end
        end
        if (list_done) begin
            if (done_q.size() == 0) flag("list_done", "unexpected pulse, none required");
            else begin
                s = done_q.pop_front();
                chk("skip_cnt", 32'(skip_cnt), 32'(s));
                $display("list_done skip_cnt=%0d", skip_cnt);
            end
        end
    end

    // ---------------- reference model ----------------
    // From the list contents alone: addresses 0..cnt-1 are read, non-skipped
    // entries are issued in order, and the timing gaps are 2 cycles per
    // skipped entry.
    task automatic model_list(input int cnt);
        int   run;
        int   skipped;
        exp_t e;
        run = 0;
        skipped = 0;
        gap_q.delete();
        for (int i = 0; i < cnt; i++) begin
            addr_q.push_back(i);
            if (SKIP && mem[i][47:0] == 48'd0) begin
                skipped++;
                run++;
            end else begin
                e.row = mem[i][79:64];
                e.col = mem[i][63:48];
                e.re  = mem[i][47:24];
                e.im  = mem[i][23:0];
                e.idx = i;
                exp_q.push_back(e);
                gap_q.push_back(run);
                last_exp = e;
                run = 0;
            end
        end
        trail = run;
        done_q.push_back(skipped);
    endtask

    task automatic clear_model();
        exp_q.delete();
        addr_q.delete();
        done_q.delete();
        last_exp = '{16'd0, 16'd0, 24'd0, 24'd0, 0};
    endtask

    // ---------------- drivers ----------------
    task automatic do_start(input int cnt);
        @(posedge clock); #1;
        chg_count = CW'(cnt);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    // Entered at the negedge of the ISSUE cycle.
    task automatic drive_done(input int d, input bit noisy);
        if (noisy) begin
            upd_done = 1'b1;
            start    = 1'b1;
        end
        @(posedge clock); #1;
        upd_done = 1'b0;
        start    = 1'b0;
        repeat (d) begin
            @(posedge clock); #1;
        end
        upd_done = 1'b1;
        @(posedge clock); #1;
        upd_done = 1'b0;
    endtask

    task automatic wait_for(input bit want_done, input int exp_lat, input string name, output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        while (n < 40 && !ok) begin
            @(negedge clock);
            n++;
            ok = want_done ? list_done : entry_valid;
        end
        if (!ok) flag(name, $sformatf("no pulse within 40 cycles, required one after %0d", exp_lat));
        else chk({name, " latency"}, 32'(n), 32'(exp_lat));
    endtask

    task automatic recover();
        @(posedge clock); #1;
        reset = 1'b0;
        upd_done = 1'b0;
        start = 1'b0;
        clear_model();
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    task automatic check_retained();
        chk("busy after done", 32'(busy), 32'd0);
        chk("kept row", 32'(chgTxt_row), 32'(last_exp.row));
        chk("kept col", 32'(chgTxt_col), 32'(last_exp.col));
        chk("kept real", 32'(chgTxt_real), 32'(last_exp.re));
        chk("kept img", 32'(chgTxt_img), 32'(last_exp.im));
        chk("kept entry_idx", 32'(entry_idx), 32'(last_exp.idx));
        chk("entries outstanding", 32'(exp_q.size()), 32'd0);
        chk("reads outstanding", 32'(addr_q.size()), 32'd0);
    endtask

    task automatic run_list(input int cnt, input int fixed_d, input bit noisy);
        bit ok;
        int d;
        model_list(cnt);
        $display("list cnt=%0d noisy=%0d issued=%0d", cnt, noisy, gap_q.size());
        do_start(cnt);
        foreach (gap_q[k]) begin
            wait_for(1'b0, 3 + 2 * gap_q[k], "entry_valid", ok);
            if (!ok) begin
                recover();
                return;
            end
            chk("busy in ISSUE", 32'(busy), 32'd1);
            d = (fixed_d >= 0) ? fixed_d : int'($urandom_range(0, 4));
            drive_done(d, noisy);
        end
        wait_for(1'b1, 1 + 2 * trail, "list_done", ok);
        if (!ok) begin
            recover();
            return;
        end
        repeat (3) @(posedge clock);
        #1 check_retained();
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, " chg_rd_en"}, 32'(chg_rd_en), 32'd0);
        chk({tag, " chg_addr"}, 32'(chg_addr), 32'd0);
        chk({tag, " row"}, 32'(chgTxt_row), 32'd0);
        chk({tag, " col"}, 32'(chgTxt_col), 32'd0);
        chk({tag, " real"}, 32'(chgTxt_real), 32'd0);
        chk({tag, " img"}, 32'(chgTxt_img), 32'd0);
        chk({tag, " entry_valid"}, 32'(entry_valid), 32'd0);
        chk({tag, " entry_idx"}, 32'(entry_idx), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " list_done"}, 32'(list_done), 32'd0);
        chk({tag, " skip_cnt"}, 32'(skip_cnt), 32'd0);
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        bit ok;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        clear_model();

        repeat (3) @(posedge clock);
        #1 check_zero_outputs("reset");
        reset = 1'b1;

        // Reset in WAIT_DONE of entry 1 of 4.
        for (int i = 0; i < DEPTH; i++)
            mem[i] = {16'(10 + i), 16'(20 + i), 24'(100 + i), 24'(200 + i)};
        model_list(4);
        do_start(4);
        wait_for(1'b0, 3, "entry_valid", ok);
        if (ok) begin
            drive_done(1, 1'b0);
            wait_for(1'b0, 3, "entry_valid", ok);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        clear_model();
        #1 check_zero_outputs("mid-list reset");
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        repeat (4) @(posedge clock);
        #1 chk("no list_done after reset", 32'(done_q.size()), 32'd0);
        run_list(4, 1, 1'b0);

        // Directed three-entry list, done 5 cycles after each entry_valid.
        mem[0] = {16'd1, 16'd2, 24'h000010, 24'h000020};
        mem[1] = {16'd5, 16'd7, 24'hFFFFF0, 24'h000001};
        mem[2] = {16'd9, 16'd9, 24'h000001, 24'h000001};
        run_list(3, 4, 1'b0);
        // Same list with done during ISSUE and stray start pulses.
        run_list(3, 4, 1'b1);

        // Empty list.
        run_list(0, 0, 1'b0);

        // Full list (2^ADDR_W entries).
        mem[3] = {16'hABCD, 16'h1234, 24'h7FFFFF, 24'h800000};
        run_list(4, 2, 1'b0);

        // Middle entry zero: skipped only when the skip feature is built in.
        mem[1] = {16'd3, 16'd4, 24'd0, 24'd0};
        run_list(3, 1, 1'b0);

        // Random lists.
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i][79:48] = $urandom;
                if ($urandom_range(0, 2) == 0) mem[i][47:0] = '0;
                else mem[i][47:0] = {$urandom, $urandom};
            end
            run_list(int'($urandom_range(0, 4)), -1, 1'(($urandom_range(0, 1))));
        end

        repeat (5) @(posedge clock);
        #1 chk("final entries outstanding", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
